// File: rtl/mod_sub_pipe.sv
// Two-stage pipelined modular subtractor: (a - b) mod m with operand range checking.
// Stage 1 holds the borrow-extended difference, stage 2 applies the +m correction.
module mod_sub_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             out_err
);

    logic             v1_q, v1_d;
    logic [WIDTH:0]   d_q, d_d;
    logic [WIDTH-1:0] m1_q, m1_d;
    logic             e1_q, e1_d;
    logic             v2_q, v2_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;

    logic ready1, ready2, accept, advance;

    // Each stage may load whenever the stage after it can take its contents this cycle.
    assign ready2  = !v2_q || out_ready;
    assign ready1  = !v1_q || ready2;
    assign accept  = in_valid && ready1;
    assign advance = v1_q && ready2;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        v1_d  = v1_q;
        d_d   = d_q;
        m1_d  = m1_q;
        e1_d  = e1_q;
        v2_d  = v2_q;
        res_d = res_q;
        err_d = err_q;

        if (accept) begin
            v1_d = 1'b1;
            d_d  = {1'b0, a} - {1'b0, b};
            m1_d = m;
            e1_d = (m == '0) || (a >= m) || (b >= m);
        end else if (advance) begin
            v1_d = 1'b0;
        end

        if (advance) begin
            v2_d  = 1'b1;
            err_d = e1_q;
            if (e1_q) begin
                res_d = '0;
            end else if (d_q[WIDTH]) begin
                // Truncation is exact: with a, b < m the corrected value is below m.
                res_d = d_q[WIDTH-1:0] + m1_q;
            end else begin
                res_d = d_q[WIDTH-1:0];
            end
        end else if (v2_q && out_ready) begin
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: datapath registers are cleared too, so result reads 0 straight out of reset.
            v1_q  <= 1'b0;
            d_q   <= '0;
            m1_q  <= '0;
            e1_q  <= 1'b0;
            v2_q  <= 1'b0;
            res_q <= '0;
            err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            v1_q  <= v1_d;
            d_q   <= d_d;
            m1_q  <= m1_d;
            e1_q  <= e1_d;
            v2_q  <= v2_d;
            res_q <= res_d;
            err_q <= err_d;
        end
    end

    assign in_ready  = ready1;
    assign out_valid = v2_q;
    assign result    = res_q;
    assign out_err   = err_q;

endmodule
